// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback control FSM for the 16-bit core.
// Owns pc and ir; turns decoder outputs into ALU, shifter, register-file and data-memory strobes.
module instr_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [15:0]     ir,
    input  logic [4:0]      aluop,
    input  logic [7:0]      immdata,
    input  logic            shiftflag,
    input  logic            flag_z,
    input  logic            flag_c,
    input  logic            flag_s,
    output logic            alu_en,
    output logic            shift_start,
    input  logic            shift_done,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            rf_we,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_SHIFT  = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t          cur, nxt;
    logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, br_target;
    logic [15:0]     ir_q, ir_nxt;
    logic            taken;
    logic            imem_req_c, alu_en_c, shift_start_c, dmem_req_c, dmem_we_c, rf_we_c;

    assign pc_inc    = pc_q + PC_W'(1);
    assign br_target = PC_W'(immdata);

    // Flags reflect the previous instruction's latched ALU result.
    always_comb begin
        taken = 1'b0;
        case (aluop)
            5'd19:   taken = flag_z;
            5'd20:   taken = flag_c;
            5'd21:   taken = !flag_c && !flag_z;
            5'd22:   taken = flag_s;
            5'd23:   taken = !flag_s && !flag_z;
            5'd24:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= S_FETCH;
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            cur  <= nxt;
            pc_q <= pc_nxt;
            ir_q <= ir_nxt;
        end
    end

    always_comb begin
        nxt           = cur;
        pc_nxt        = pc_q;
        ir_nxt        = ir_q;
        imem_req_c    = 1'b0;
        alu_en_c      = 1'b0;
        shift_start_c = 1'b0;
        dmem_req_c    = 1'b0;
        dmem_we_c     = 1'b0;
        rf_we_c       = 1'b0;
        case (cur)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_nxt = imem_data;
                    nxt    = S_DECODE;
                end
            end
            S_DECODE: nxt = S_EXEC;
            S_EXEC: begin
                if (aluop == 5'd0 || aluop == 5'd31) begin
                    pc_nxt = pc_inc;
                    nxt    = S_FETCH;
                end else if (shiftflag) begin
                    shift_start_c = 1'b1;
                    nxt           = S_SHIFT;
                end else begin
                    case (aluop)
                        5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                        5'd14, 5'd15, 5'd25, 5'd28: begin
                            alu_en_c = 1'b1;
                            nxt      = S_WB;
                        end
                        5'd16, 5'd17, 5'd18: begin
                            alu_en_c = 1'b1;
                            pc_nxt   = pc_inc;
                            nxt      = S_FETCH;
                        end
                        5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24: begin
                            pc_nxt = taken ? br_target : pc_inc;
                            nxt    = S_FETCH;
                        end
                        5'd26, 5'd27, 5'd29, 5'd30: nxt = S_MEM;
                        default: begin
                            pc_nxt = pc_inc;
                            nxt    = S_FETCH;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                if (shift_done) nxt = S_WB;
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (aluop == 5'd27);
                if (dmem_ack) begin
                    if (aluop == 5'd26) begin
                        nxt = S_WB;
                    end else begin
                        pc_nxt = pc_inc;
                        nxt    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we_c = 1'b1;
                pc_nxt  = pc_inc;
                nxt     = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // Strobes are masked by rst so an aborted instruction emits nothing on the reset edge.
    assign imem_req    = imem_req_c && !rst;
    assign alu_en      = alu_en_c && !rst;
    assign shift_start = shift_start_c && !rst;
    assign dmem_req    = dmem_req_c && !rst;
    assign dmem_we     = dmem_we_c && !rst;
    assign rf_we       = rf_we_c && !rst;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign state       = cur;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a vector table of single instructions with
// hand-computed cycle counts, strobe counts and resulting pc, plus a reset-abort sequence.
module tb_instr_sequencer;

    localparam int PC_W = 8;
    localparam logic [2:0] ST_FETCH = 3'd0, ST_EXEC = 3'd2, ST_SHIFT = 3'd3, ST_MEM = 3'd4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req, imem_ack = 1'b0;
    logic [PC_W-1:0] imem_addr, pc;
    logic [15:0]     imem_data = '0, ir;
    logic [4:0]      aluop = '0;
    logic [7:0]      immdata = '0;
    logic            shiftflag = 1'b0, flag_z = 1'b0, flag_c = 1'b0, flag_s = 1'b0;
    logic            alu_en, shift_start, shift_done = 1'b0;
    logic            dmem_req, dmem_we, dmem_ack = 1'b0, rf_we;
    logic [2:0]      state;

    int n_checks = 0;
    int n_fail   = 0;

    instr_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(ir), .aluop(aluop), .immdata(immdata), .shiftflag(shiftflag),
        .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s),
        .alu_en(alu_en), .shift_start(shift_start), .shift_done(shift_done),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .pc(pc), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0] aluop;
        logic [7:0] imm;
        logic       sf, fz, fc, fs;
        int         iw, mw, sw;
        int         e_cyc, e_alu, e_alu_at, e_rf, e_rf_at, e_ss, e_dreq, e_dwe, e_ireq;
        logic [7:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [7:0] imm, input logic sf,
                                input logic fz, input logic fc, input logic fs,
                                input int iw, input int mw, input int sw,
                                input int cyc, input int alu, input int alu_at, input int rf,
                                input int rf_at, input int ss, input int dreq, input int dwe,
                                input int ireq, input logic [7:0] npc);
        vec_t v;
        v.aluop = op; v.imm = imm; v.sf = sf; v.fz = fz; v.fc = fc; v.fs = fs;
        v.iw = iw; v.mw = mw; v.sw = sw;
        v.e_cyc = cyc; v.e_alu = alu; v.e_alu_at = alu_at; v.e_rf = rf; v.e_rf_at = rf_at;
        v.e_ss = ss; v.e_dreq = dreq; v.e_dwe = dwe; v.e_ireq = ireq; v.e_pc = npc;
        return v;
    endfunction

    // Runs one instruction from FETCH back to FETCH; acks follow per-state wait counts.
    // Stray shift_done/dmem_ack are raised during EXEC and must be ignored.
    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0, fcnt = 0, mcnt = 0, scnt = 0;
        int n_alu = 0, alu_at = 0, n_rf = 0, rf_at = 0, n_ss = 0, n_dreq = 0, n_dwe = 0, n_ireq = 0;
        bit left = 0;
        aluop = v.aluop; immdata = v.imm; shiftflag = v.sf;
        flag_z = v.fz; flag_c = v.fc; flag_s = v.fs;
        imem_data = {v.aluop, 3'b101, v.imm};
        while (cyc < 60) begin
            imem_ack   = (state == ST_FETCH) && (fcnt == v.iw);
            dmem_ack   = ((state == ST_MEM) && (mcnt == v.mw)) || (state == ST_EXEC);
            shift_done = ((state == ST_SHIFT) && (scnt == v.sw)) || (state == ST_EXEC);
            if (state == ST_FETCH) fcnt++;
            if (state == ST_MEM)   mcnt++;
            if (state == ST_SHIFT) scnt++;
            if (state != ST_FETCH) left = 1;
            #1;
            cyc++;
            if (alu_en) begin n_alu++; if (alu_at == 0) alu_at = cyc; end
            if (rf_we)  begin n_rf++;  if (rf_at == 0)  rf_at = cyc;  end
            if (shift_start) n_ss++;
            if (dmem_req) n_dreq++;
            if (dmem_we)  n_dwe++;
            if (imem_req) n_ireq++;
            @(posedge clk);
            @(negedge clk);
            if (state != ST_FETCH) left = 1;
            if (left && state == ST_FETCH) break;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0; shift_done = 1'b0;
        check("cycles",       idx, cyc,    v.e_cyc);
        check("alu_en_count", idx, n_alu,  v.e_alu);
        check("alu_en_cycle", idx, alu_at, v.e_alu_at);
        check("rf_we_count",  idx, n_rf,   v.e_rf);
        check("rf_we_cycle",  idx, rf_at,  v.e_rf_at);
        check("shift_start",  idx, n_ss,   v.e_ss);
        check("dmem_req_cyc", idx, n_dreq, v.e_dreq);
        check("dmem_we_cyc",  idx, n_dwe,  v.e_dwe);
        check("imem_req_cyc", idx, n_ireq, v.e_ireq);
        check("pc",           idx, pc,     v.e_pc);
        check("ir",           idx, ir,     {v.aluop, 3'b101, v.imm});
    endtask

    initial begin
        //                op     imm    sf fz fc fs iw mw sw cyc alu @  rf @  ss dr dw ir  pc
        vecs.push_back(mk(5'd1,  8'h00, 0, 0, 0, 0, 0, 0, 0, 4,  1, 3, 1, 4, 0, 0, 0, 1, 8'h01)); // add
        vecs.push_back(mk(5'd19, 8'h40, 0, 1, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'h40)); // je taken
        vecs.push_back(mk(5'd19, 8'h10, 0, 0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'h41)); // je not
        vecs.push_back(mk(5'd20, 8'h20, 0, 0, 1, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'h20)); // jb taken
        vecs.push_back(mk(5'd21, 8'h30, 0, 0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'h30)); // ja taken
        vecs.push_back(mk(5'd21, 8'h50, 0, 0, 1, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'h31)); // ja not
        vecs.push_back(mk(5'd22, 8'h60, 0, 0, 0, 1, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'h60)); // lj taken
        vecs.push_back(mk(5'd23, 8'h70, 0, 1, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'h61)); // jg not
        vecs.push_back(mk(5'd23, 8'h70, 0, 0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'h70)); // jg taken
        vecs.push_back(mk(5'd24, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'hFF)); // jmp
        vecs.push_back(mk(5'd0,  8'h00, 0, 0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'h00)); // nop wrap
        vecs.push_back(mk(5'd18, 8'h00, 0, 0, 0, 0, 0, 0, 0, 3,  1, 3, 0, 0, 0, 0, 0, 1, 8'h01)); // cmp
        vecs.push_back(mk(5'd8,  8'h00, 1, 0, 0, 0, 0, 0, 2, 7,  0, 0, 1, 7, 1, 0, 0, 1, 8'h02)); // sar
        vecs.push_back(mk(5'd27, 8'h00, 0, 0, 0, 0, 0, 2, 0, 6,  0, 0, 0, 0, 0, 3, 3, 1, 8'h03)); // stordm
        vecs.push_back(mk(5'd26, 8'h00, 0, 0, 0, 0, 0, 0, 0, 5,  0, 0, 1, 5, 0, 1, 0, 1, 8'h04)); // lm
        vecs.push_back(mk(5'd25, 8'h00, 0, 0, 0, 0, 2, 0, 0, 6,  1, 5, 1, 6, 0, 0, 0, 3, 8'h05)); // li slow fetch
        vecs.push_back(mk(5'd31, 8'h00, 0, 0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'h06)); // op 31
        vecs.push_back(mk(5'd29, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 1, 0, 1, 8'h07)); // showdm
        vecs.push_back(mk(5'd16, 8'h00, 0, 0, 0, 0, 0, 0, 0, 3,  1, 3, 0, 0, 0, 0, 0, 1, 8'h08)); // showr
        vecs.push_back(mk(5'd24, 8'h3C, 0, 1, 1, 1, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 8'h3C)); // jmp
        vecs.push_back(mk(5'd28, 8'h00, 0, 0, 0, 0, 1, 0, 0, 5,  1, 4, 1, 5, 0, 0, 0, 2, 8'h3D)); // ldip
        vecs.push_back(mk(5'd30, 8'h00, 0, 0, 0, 0, 0, 1, 0, 5,  0, 0, 0, 0, 0, 2, 0, 1, 8'h3E)); // showdmseg

        // Reset held with a stray fetch ack: nothing may move or strobe.
        imem_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state",    -1, state,       ST_FETCH);
        check("rst_pc",       -1, pc,          0);
        check("rst_ir",       -1, ir,          0);
        check("rst_imem_req", -1, imem_req,    0);
        check("rst_strobes",  -1, {alu_en, shift_start, rf_we, dmem_req, dmem_we}, 0);
        imem_ack = 1'b0;
        rst = 1'b0;
        #1;
        check("imem_req_after_rst", -1, imem_req, 1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset while a store is waiting in MEM; a late ack must be ignored.
        begin
            int guard = 0;
            aluop = 5'd27; immdata = 8'h00; shiftflag = 1'b0;
            imem_data = 16'hD800;
            imem_ack = 1'b1; dmem_ack = 1'b0;
            while (state != ST_MEM && guard < 10) begin
                @(posedge clk);
                @(negedge clk);
                guard++;
            end
            imem_ack = 1'b0;
            #1;
            check("abort_in_mem",   -2, state,    ST_MEM);
            check("abort_dmem_req", -2, dmem_req, 1);
            rst = 1'b1;
            #1;
            check("abort_rst_gates_req", -2, {dmem_req, dmem_we, rf_we}, 0);
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            dmem_ack = 1'b1;
            #1;
            check("abort_state",    -2, state,    ST_FETCH);
            check("abort_pc",       -2, pc,       0);
            check("abort_dmem_req", -2, dmem_req, 0);
            check("abort_rf_we",    -2, rf_we,    0);
            @(posedge clk);
            @(negedge clk);
            #1;
            check("late_ack_state", -2, state, ST_FETCH);
            check("late_ack_pc",    -2, pc,    0);
            check("late_ack_rf_we", -2, rf_we, 0);
            dmem_ack = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
